// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types: fetch states, IF/ID latch, opcodes
package mips_pkg;

  localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0020;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] ir;
    logic        valid;
  } ifid_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic ifid_t make_bubble(input logic [31:0] nop_word);
    ifid_t b;
    b.pc4   = 32'h0;
    b.ir    = nop_word;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// rtl/mips_fetch_stage_if.sv - fetch stage control, program-load and IF/ID bundle
interface mips_fetch_stage_if #(
  parameter int IMEM_WORDS = 64
);
  localparam int AW = $clog2(IMEM_WORDS);

  logic          stall_i;
  logic          branch_taken_i;
  logic [31:0]   branch_target_i;
  logic          imem_we_i;
  logic [AW-1:0] imem_waddr_i;
  logic [31:0]   imem_wdata_i;
  logic [31:0]   pc_o;
  logic [31:0]   ifid_pc4_o;
  logic [31:0]   ifid_ir_o;
  logic          ifid_valid_o;
  logic          halted_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_fetched_o;
  logic [31:0]   perf_stall_o;
  logic [31:0]   perf_flush_o;

  modport master (
    input  stall_i, branch_taken_i, branch_target_i,
    input  imem_we_i, imem_waddr_i, imem_wdata_i,
    output pc_o, ifid_pc4_o, ifid_ir_o, ifid_valid_o, halted_o,
    output perf_fetched_o, perf_stall_o, perf_flush_o
  );

  modport slave (
    output stall_i, branch_taken_i, branch_target_i,
    output imem_we_i, imem_waddr_i, imem_wdata_i,
    input  pc_o, ifid_pc4_o, ifid_ir_o, ifid_valid_o, halted_o,
    input  perf_fetched_o, perf_stall_o, perf_flush_o
  );
`else
  modport master (
    input  stall_i, branch_taken_i, branch_target_i,
    input  imem_we_i, imem_waddr_i, imem_wdata_i,
    output pc_o, ifid_pc4_o, ifid_ir_o, ifid_valid_o, halted_o
  );

  modport slave (
    output stall_i, branch_taken_i, branch_target_i,
    output imem_we_i, imem_waddr_i, imem_wdata_i,
    input  pc_o, ifid_pc4_o, ifid_ir_o, ifid_valid_o, halted_o
  );
`endif

endinterface

// File: rtl/mips_imem.sv
// rtl/mips_imem.sv - instruction memory: synchronous load port, combinational read
module mips_imem #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Program load; a read of the same index this cycle still sees the old word
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_fetch_stage.sv
// rtl/mips_fetch_stage.sv - MIPS IF stage: PC, IMEM, IF/ID latch; FETCH_PERF_CNT_EN adds perf counters
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEF
) (
  input logic                  clock,
  input logic                  reset_n,
  mips_fetch_stage_if.master   fif
);

  localparam int AW = $clog2(IMEM_WORDS);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  ifid_t        ifid_q, ifid_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  fetch_word;
  logic         evt_fetch, evt_stall, evt_flush;

  mips_imem #(.WORDS(IMEM_WORDS), .AW(AW)) u_imem (
    .clock (clock),
    .we    (fif.imem_we_i),
    .waddr (fif.imem_waddr_i),
    .wdata (fif.imem_wdata_i),
    .raddr (pc_q[AW+1:2]),
    .rdata (fetch_word)
  );

  assign pc_plus4 = pc_q + 32'd4;

  // State, PC and IF/ID latch; async reset puts a bubble in the latch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      ifid_q  <= make_bubble(NOP_WORD);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  // Next state: branch beats stall beats normal fetch; stall only matters in RUN
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ifid_d    = ifid_q;
    evt_fetch = 1'b0;
    evt_stall = 1'b0;
    evt_flush = 1'b0;
    if (fif.branch_taken_i) begin
      pc_d      = fif.branch_target_i & 32'hFFFF_FFFC;
      ifid_d    = make_bubble(NOP_WORD);
      state_d   = ST_RUN;
      evt_flush = 1'b1;
    end else begin
      case (state_q)
        ST_BOOT: begin
          ifid_d  = make_bubble(NOP_WORD);
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (fif.stall_i) begin
            evt_stall = 1'b1;
          end else if (fetch_word == HALT_WORD) begin
            ifid_d  = make_bubble(NOP_WORD);
            state_d = ST_HALT;
          end else begin
            ifid_d.pc4   = pc_plus4;
            ifid_d.ir    = fetch_word;
            ifid_d.valid = 1'b1;
            pc_d         = pc_plus4;
            evt_fetch    = 1'b1;
          end
        end
        ST_HALT: begin
          ifid_d = make_bubble(NOP_WORD);
        end
        default: begin
          ifid_d  = make_bubble(NOP_WORD);
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  assign fif.pc_o         = pc_q;
  assign fif.ifid_pc4_o   = ifid_q.pc4;
  assign fif.ifid_ir_o    = ifid_q.ir;
  assign fif.ifid_valid_o = ifid_q.valid;
  assign fif.halted_o     = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_fetched_q, cnt_stall_q, cnt_flush_q;

  // Saturating event counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_fetched_q <= 32'h0;
      cnt_stall_q   <= 32'h0;
      cnt_flush_q   <= 32'h0;
    end else begin
      if (evt_fetch && cnt_fetched_q != 32'hFFFF_FFFF) cnt_fetched_q <= cnt_fetched_q + 32'd1;
      if (evt_stall && cnt_stall_q   != 32'hFFFF_FFFF) cnt_stall_q   <= cnt_stall_q + 32'd1;
      if (evt_flush && cnt_flush_q   != 32'hFFFF_FFFF) cnt_flush_q   <= cnt_flush_q + 32'd1;
    end
  end

  assign fif.perf_fetched_o = cnt_fetched_q;
  assign fif.perf_stall_o   = cnt_stall_q;
  assign fif.perf_flush_o   = cnt_flush_q;
`else
  logic unused_evt;
  assign unused_evt = evt_fetch ^ evt_stall ^ evt_flush;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb/tb_mips_fetch_stage.sv - directed self-checking bench for mips_fetch_stage
module tb_mips_fetch_stage;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  mips_fetch_stage_if #(.IMEM_WORDS(64)) fif ();

  mips_fetch_stage #(.IMEM_WORDS(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .fif     (fif)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    fif.stall_i         = 1'b0;
    fif.branch_taken_i  = 1'b0;
    fif.branch_target_i = 32'h0;
    fif.imem_we_i       = 1'b0;
    fif.imem_waddr_i    = '0;
    fif.imem_wdata_i    = 32'h0;
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    fif.imem_we_i    = 1'b1;
    fif.imem_waddr_i = 6'(idx);
    fif.imem_wdata_i = data;
    tick();
    fif.imem_we_i    = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    for (int i = 0; i < 64; i++) load_word(i, 32'h0000_0020);
    load_word(0, 32'h0041_2820);
    load_word(1, 32'h8CA3_0004);
    load_word(2, 32'h0000_0020);
    load_word(3, 32'hFFFF_FFFF);
    load_word(4, 32'h2002_0005);
    load_word(63, 32'h2008_0063);
    checks++; if (fif.pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", fif.pc_o, 32'h0); end
    checks++; if (fif.ifid_ir_o !== 32'h20) begin errors++; $display("FAIL reset_ir got=%h exp=%h", fif.ifid_ir_o, 32'h20); end
    checks++; if (fif.ifid_pc4_o !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=%h", fif.ifid_pc4_o, 32'h0); end
    checks++; if (fif.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", fif.ifid_valid_o); end
    checks++; if (fif.halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", fif.halted_o); end
    reset_n = 1'b1;
  endtask

  task automatic test_program_and_halt();
    tick();
    checks++; if (fif.ifid_valid_o !== 1'b0 || fif.pc_o !== 32'h0) begin errors++; $display("FAIL boot_bubble got valid=%b pc=%h exp valid=0 pc=0", fif.ifid_valid_o, fif.pc_o); end
    tick();
    checks++; if (fif.ifid_ir_o !== 32'h0041_2820 || fif.ifid_pc4_o !== 32'h4 || fif.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL fetch0 got ir=%h pc4=%h v=%b exp ir=00412820 pc4=4 v=1", fif.ifid_ir_o, fif.ifid_pc4_o, fif.ifid_valid_o); end
    tick();
    checks++; if (fif.ifid_ir_o !== 32'h8CA3_0004 || fif.ifid_pc4_o !== 32'h8) begin errors++; $display("FAIL fetch1 got ir=%h pc4=%h exp ir=8ca30004 pc4=8", fif.ifid_ir_o, fif.ifid_pc4_o); end
    tick();
    checks++; if (fif.ifid_ir_o !== 32'h0000_0020 || fif.ifid_pc4_o !== 32'hC || fif.pc_o !== 32'hC) begin errors++; $display("FAIL fetch2 got ir=%h pc4=%h pc=%h exp ir=00000020 pc4=c pc=c", fif.ifid_ir_o, fif.ifid_pc4_o, fif.pc_o); end
    tick();
    checks++; if (fif.halted_o !== 1'b1 || fif.pc_o !== 32'hC || fif.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL halt_enter got halted=%b pc=%h v=%b exp halted=1 pc=c v=0", fif.halted_o, fif.pc_o, fif.ifid_valid_o); end
    fif.stall_i = 1'b1;
    tick();
    tick();
    fif.stall_i = 1'b0;
    checks++; if (fif.halted_o !== 1'b1 || fif.pc_o !== 32'hC || fif.ifid_ir_o !== 32'h20) begin errors++; $display("FAIL halt_frozen got halted=%b pc=%h ir=%h exp halted=1 pc=c ir=20", fif.halted_o, fif.pc_o, fif.ifid_ir_o); end
  endtask

  task automatic test_halt_branch();
    fif.branch_taken_i  = 1'b1;
    fif.branch_target_i = 32'h0;
    fif.stall_i         = 1'b1;
    tick();
    clear_inputs();
    checks++; if (fif.halted_o !== 1'b0 || fif.pc_o !== 32'h0 || fif.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL halt_branch got halted=%b pc=%h v=%b exp halted=0 pc=0 v=0", fif.halted_o, fif.pc_o, fif.ifid_valid_o); end
    tick();
    checks++; if (fif.ifid_ir_o !== 32'h0041_2820 || fif.ifid_pc4_o !== 32'h4 || fif.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL halt_refetch got ir=%h pc4=%h v=%b exp ir=00412820 pc4=4 v=1", fif.ifid_ir_o, fif.ifid_pc4_o, fif.ifid_valid_o); end
  endtask

  task automatic test_stall();
    apply_reset();
    tick();
    tick();
    tick();
    fif.stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (fif.ifid_ir_o !== 32'h8CA3_0004 || fif.ifid_pc4_o !== 32'h8 || fif.pc_o !== 32'h8 || fif.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got ir=%h pc4=%h pc=%h v=%b exp ir=8ca30004 pc4=8 pc=8 v=1", i, fif.ifid_ir_o, fif.ifid_pc4_o, fif.pc_o, fif.ifid_valid_o); end
    end
    fif.stall_i = 1'b0;
    tick();
    checks++; if (fif.ifid_ir_o !== 32'h0000_0020 || fif.pc_o !== 32'hC || fif.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL stall_resume got ir=%h pc=%h v=%b exp ir=00000020 pc=c v=1", fif.ifid_ir_o, fif.pc_o, fif.ifid_valid_o); end
  endtask

  task automatic test_branch();
    apply_reset();
    tick();
    tick();
    fif.branch_taken_i  = 1'b1;
    fif.branch_target_i = 32'h0000_0013;
    fif.stall_i         = 1'b1;
    tick();
    clear_inputs();
    checks++; if (fif.pc_o !== 32'h10 || fif.ifid_valid_o !== 1'b0 || fif.ifid_ir_o !== 32'h20) begin errors++; $display("FAIL branch_redirect got pc=%h v=%b ir=%h exp pc=10 v=0 ir=20", fif.pc_o, fif.ifid_valid_o, fif.ifid_ir_o); end
    tick();
    checks++; if (fif.ifid_ir_o !== 32'h2002_0005 || fif.ifid_pc4_o !== 32'h14 || fif.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL branch_target_fetch got ir=%h pc4=%h v=%b exp ir=20020005 pc4=14 v=1", fif.ifid_ir_o, fif.ifid_pc4_o, fif.ifid_valid_o); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick();
    tick();
    fif.branch_taken_i  = 1'b1;
    fif.branch_target_i = 32'h40;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (fif.pc_o !== 32'h0 || fif.ifid_ir_o !== 32'h20 || fif.ifid_valid_o !== 1'b0 || fif.ifid_pc4_o !== 32'h0 || fif.halted_o !== 1'b0) begin errors++; $display("FAIL async_reset got pc=%h ir=%h v=%b pc4=%h h=%b exp pc=0 ir=20 v=0 pc4=0 h=0", fif.pc_o, fif.ifid_ir_o, fif.ifid_valid_o, fif.ifid_pc4_o, fif.halted_o); end
    clear_inputs();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_wrap();
    apply_reset();
    tick();
    fif.branch_taken_i  = 1'b1;
    fif.branch_target_i = 32'h0000_00FC;
    tick();
    clear_inputs();
    tick();
    checks++; if (fif.ifid_ir_o !== 32'h2008_0063 || fif.ifid_pc4_o !== 32'h100 || fif.pc_o !== 32'h100) begin errors++; $display("FAIL wrap_last got ir=%h pc4=%h pc=%h exp ir=20080063 pc4=100 pc=100", fif.ifid_ir_o, fif.ifid_pc4_o, fif.pc_o); end
    tick();
    checks++; if (fif.ifid_ir_o !== 32'h0041_2820 || fif.ifid_pc4_o !== 32'h104) begin errors++; $display("FAIL wrap_index0 got ir=%h pc4=%h exp ir=00412820 pc4=104", fif.ifid_ir_o, fif.ifid_pc4_o); end
    fif.branch_taken_i  = 1'b1;
    fif.branch_target_i = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    tick();
    checks++; if (fif.ifid_ir_o !== 32'h2008_0063 || fif.ifid_pc4_o !== 32'h0 || fif.pc_o !== 32'h0) begin errors++; $display("FAIL pc_wrap32 got ir=%h pc4=%h pc=%h exp ir=20080063 pc4=0 pc=0", fif.ifid_ir_o, fif.ifid_pc4_o, fif.pc_o); end
  endtask

  task automatic test_write_during_read();
    apply_reset();
    tick();
    tick();
    fif.imem_we_i    = 1'b1;
    fif.imem_waddr_i = 6'd1;
    fif.imem_wdata_i = 32'hDEAD_0001;
    tick();
    fif.imem_we_i    = 1'b0;
    checks++; if (fif.ifid_ir_o !== 32'h8CA3_0004) begin errors++; $display("FAIL write_read_old got=%h exp=8ca30004", fif.ifid_ir_o); end
    load_word(1, 32'h8CA3_0004);
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    clear_inputs();
    reset_n = 1'b0;
    #1;
    checks++; if (fif.perf_fetched_o !== 32'h0 || fif.perf_stall_o !== 32'h0 || fif.perf_flush_o !== 32'h0) begin errors++; $display("FAIL perf_reset got f=%0d s=%0d b=%0d exp 0 0 0", fif.perf_fetched_o, fif.perf_stall_o, fif.perf_flush_o); end
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    fif.stall_i = 1'b1;
    tick();
    fif.stall_i = 1'b0;
    tick();
    fif.branch_taken_i  = 1'b1;
    fif.branch_target_i = 32'h0;
    tick();
    clear_inputs();
    tick();
    checks++; if (fif.perf_fetched_o !== 32'd3) begin errors++; $display("FAIL perf_fetched got=%0d exp=3", fif.perf_fetched_o); end
    checks++; if (fif.perf_stall_o !== 32'd1) begin errors++; $display("FAIL perf_stall got=%0d exp=1", fif.perf_stall_o); end
    checks++; if (fif.perf_flush_o !== 32'd1) begin errors++; $display("FAIL perf_flush got=%0d exp=1", fif.perf_flush_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_program_and_halt();
    test_halt_branch();
    test_stall();
    test_branch();
    test_async_reset();
    test_wrap();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_write_during_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, the instruction memory and the IF/ID pipeline latch, and feeds the decode stage. It honours stall requests from the hazard unit and redirects from branch resolution. It stops fetching when it reaches a halt word, so testbenches finish deterministically.

Parameters:
IMEM_WORDS, 64, instruction memory depth in 32-bit words (power of two)
RESET_PC, 32'h0000_0000, PC value loaded at reset (word aligned)
NOP_WORD, 32'h0000_0020, bubble inserted on flush/boot/halt (add r0,r0,r0)
HALT_WORD, 32'hFFFF_FFFF, fetched word that stops the fetcher

Ports:
clock  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
stall_i  input  1  hazard unit: hold PC and IF/ID latch this cycle
branch_taken_i  input  1  branch/jump resolved taken; redirect fetch
branch_target_i  input  32  redirect byte address
imem_we_i  input  1  program-load write strobe
imem_waddr_i  input  $clog2(IMEM_WORDS)  program-load word index
imem_wdata_i  input  32  program-load data
pc_o  output  32  current fetch PC
ifid_pc4_o  output  32  IF/ID.PC+4 of latched instruction
ifid_ir_o  output  32  IF/ID.IR
ifid_valid_o  output  1  IF/ID holds a real instruction (0 = bubble)
halted_o  output  1  fetcher is in HALT

Behaviour:
- Reset (async, reset_n=0): pc_o=RESET_PC, ifid_ir_o=NOP_WORD, ifid_pc4_o=0, ifid_valid_o=0, halted_o=0, state=BOOT. IMEM contents are not cleared.
- IMEM read is combinational. Index = PC[$clog2(IMEM_WORDS)+1:2]. The index wraps modulo IMEM_WORDS and PC[1:0] is ignored.
- IMEM write is synchronous on imem_we_i. It is allowed in any state. A same-cycle write/read of one index returns the old word.
- State machine (2-bit): BOOT, RUN, HALT.
  - BOOT: lasts exactly one cycle after reset release. Emits a bubble, PC unchanged, goes to RUN. This gives a program-load cycle margin.
  - RUN, normal cycle: IF/ID <= {PC+4, IMEM[idx], valid=1}; PC <= PC+4.
  - RUN, fetched word == HALT_WORD: IF/ID <= bubble; PC held; next state HALT; halted_o=1 next cycle.
  - HALT: IF/ID held as bubble, PC frozen.
- Priority per cycle: branch_taken_i > stall_i > normal fetch.
  - Branch: PC <= {branch_target_i[31:2],2'b00}; IF/ID <= bubble (valid=0, IR=NOP_WORD); state <= RUN from RUN, HALT or BOOT; halted_o clears. An older branch can cancel a speculatively fetched halt.
  - Stall, no branch: PC and IF/ID hold all fields. A stall in HALT has no effect.
- Latency: an instruction at PC appears on ifid_ir_o one cycle after pc_o==PC with no stall. The branch redirect penalty is one bubble.
- PC+4 arithmetic is 32-bit and wraps 32'hFFFF_FFFC -> 0.
- Reset mid-operation clears state and the latch immediately (async), regardless of stall or branch.

Optional Feature:
FETCH_PERF_CNT_EN — when defined, three extra 32-bit outputs are added: perf_fetched_o (valid instructions latched), perf_stall_o (RUN cycles with stall_i and no branch), perf_flush_o (branch redirects).
- Counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and counters are absent and the base behaviour is unchanged.

Decomposition:
- Package mips_pkg: NOP_WORD/HALT_WORD defaults, fetch state enum (BOOT/RUN/HALT), IF/ID struct {pc4, ir, valid}, opcode constants shared with decode.
- One sub-module, mips_imem: synchronous-write, async-read word array with a load port. The fetch stage wraps it.

Test Plan:
- Load IMEM[0..3]=32'h00412820,32'h8CA30004,32'h00000020,32'hFFFFFFFF, release reset -> cycle 1 bubble (BOOT). Cycles 2-4 IR=00412820,8CA30004,00000020 with pc4=4,8,C. Then halted_o=1 with PC frozen at 32'hC.
- stall_i high 2 cycles while ifid_ir_o=8CA30004 -> IR, pc4=8 and pc_o=8 held. Fetch resumes with IR=00000020.
- branch_taken_i=1, target=32'h0000_0013 at pc_o=4 -> next pc_o=32'h10, ifid_valid_o=0, IR=00000020.
- In HALT, branch_taken_i with target 32'h0 -> halted_o=0 and refetch from IMEM[0]. Simultaneous stall_i=1 is ignored (branch wins).
- Assert reset_n low mid-stream between edges -> outputs return to reset values without a clock edge. Write IMEM[63] and branch to 32'h100 -> fetch wraps to index 0 (IMEM_WORDS=64).
- With FETCH_PERF_CNT_EN: scenario 1 plus one stall and one branch -> perf_fetched_o=3+, perf_stall_o=1, perf_flush_o=1, exact per script.
